// File: rtl/lpgbt_uplink_capture.sv
// Snapshot buffer for lpGBT uplink user-data frames with masked trigger,
// plus saturating FEC-correction and uplink-ready dropout counters.
module lpgbt_uplink_capture #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk40,
    input  logic                  rst,
    input  logic                  uplinkrdy_i,
    input  logic [233:0]          uplinkUserData_i,
    input  logic                  uplinkFEC_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic [31:0]           trig_mask_i,
    input  logic [31:0]           trig_value_i,
    input  logic [DEPTH_LOG2:0]   capture_len_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2+2:0] rd_addr_i,
    output logic [31:0]           rd_data_o,
    output logic                  rd_valid_o,
    output logic [1:0]            state_o,
    output logic                  done_o,
    output logic [DEPTH_LOG2:0]   frames_captured_o,
    output logic [15:0]           fec_count_o,
    output logic [15:0]           rdy_loss_count_o
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << DEPTH_LOG2);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         fc_q, fc_d;
    logic [15:0]           fec_q, fec_d;
    logic [15:0]           rl_q, rl_d;
    logic                  rdy_prev_q;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q;

    logic [233:0]          mem [0:(1<<DEPTH_LOG2)-1];
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_slot;
    logic                  hit;
    logic [CW-1:0]         len_eff;
    logic [CW-1:0]         fc_inc;

    logic [DEPTH_LOG2-1:0] rd_frame;
    logic [2:0]            rd_word;
    logic [255:0]          rd_frame_wide;
    logic                  rd_hit;

    always_comb begin
        hit     = uplinkrdy_i && (((uplinkUserData_i[31:0] ^ trig_value_i) & trig_mask_i) == 32'd0);
        len_eff = ((capture_len_i == '0) || (capture_len_i > DEPTH_C)) ? DEPTH_C : capture_len_i;
        fc_inc  = fc_q + CW'(1);

        state_d = state_q;
        fc_d    = fc_q;
        wr_en   = 1'b0;
        wr_slot = fc_q[DEPTH_LOG2-1:0];
        fec_d   = (uplinkrdy_i && uplinkFEC_i && (fec_q != 16'hFFFF)) ? fec_q + 16'd1 : fec_q;
        rl_d    = (rdy_prev_q && !uplinkrdy_i && (rl_q != 16'hFFFF)) ? rl_q + 16'd1 : rl_q;

        // abort has priority over arm; arm clears status from any state
        if (abort_i) begin
            state_d = ST_IDLE;
        end else if (arm_i) begin
            state_d = ST_ARMED;
            fc_d    = '0;
            fec_d   = '0;
            rl_d    = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (hit) begin
                        wr_en   = 1'b1;
                        wr_slot = '0;
                        fc_d    = CW'(1);
                        state_d = (len_eff == CW'(1)) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (uplinkrdy_i) begin
                        wr_en = 1'b1;
                        fc_d  = fc_inc;
                        if (fc_inc >= len_eff) state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_frame      = rd_addr_i[DEPTH_LOG2+2:3];
        rd_word       = rd_addr_i[2:0];
        rd_frame_wide = {22'b0, mem[rd_frame]};
        rd_hit        = (state_q == ST_DONE) && ({1'b0, rd_frame} < fc_q);
        rd_data_d     = (rd_en_i && rd_hit) ? rd_frame_wide[{rd_word, 5'b0} +: 32] : 32'd0;
    end

    always_ff @(posedge clk40) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fc_q       <= '0;
            fec_q      <= '0;
            rl_q       <= '0;
            rdy_prev_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            fec_q      <= fec_d;
            rl_q       <= rl_d;
            rdy_prev_q <= uplinkrdy_i;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en_i;
        end
    end

    // Buffer is intentionally not reset
    always_ff @(posedge clk40) begin
        if (wr_en && !rst) mem[wr_slot] <= uplinkUserData_i;
    end

    assign state_o           = state_q;
    assign done_o            = (state_q == ST_DONE);
    assign frames_captured_o = fc_q;
    assign fec_count_o       = fec_q;
    assign rdy_loss_count_o  = rl_q;
    assign rd_data_o         = rd_data_q;
    assign rd_valid_o        = rd_valid_q;
endmodule

// File: tb/tb_lpgbt_uplink_capture.sv
// Directed bench for lpgbt_uplink_capture: trigger, capture, readout,
// arm/abort priority, reset and counter saturation.
module tb_lpgbt_uplink_capture;
    logic         clk40 = 1'b0;
    logic         rst;
    logic         uplinkrdy_i;
    logic [233:0] uplinkUserData_i;
    logic         uplinkFEC_i;
    logic         arm_i;
    logic         abort_i;
    logic [31:0]  trig_mask_i;
    logic [31:0]  trig_value_i;
    logic [4:0]   capture_len_i;
    logic         rd_en_i;
    logic [6:0]   rd_addr_i;
    logic [31:0]  rd_data_o;
    logic         rd_valid_o;
    logic [1:0]   state_o;
    logic         done_o;
    logic [4:0]   frames_captured_o;
    logic [15:0]  fec_count_o;
    logic [15:0]  rdy_loss_count_o;

    int n_cmp = 0;
    int n_err = 0;

    lpgbt_uplink_capture #(.DEPTH_LOG2(4)) dut (
        .clk40(clk40), .rst(rst), .uplinkrdy_i(uplinkrdy_i),
        .uplinkUserData_i(uplinkUserData_i), .uplinkFEC_i(uplinkFEC_i),
        .arm_i(arm_i), .abort_i(abort_i), .trig_mask_i(trig_mask_i),
        .trig_value_i(trig_value_i), .capture_len_i(capture_len_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .state_o(state_o), .done_o(done_o),
        .frames_captured_o(frames_captured_o), .fec_count_o(fec_count_o),
        .rdy_loss_count_o(rdy_loss_count_o)
    );

    always #5 clk40 = ~clk40;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    // words 1..6 = lo ^ (k * 0x11111111), top 10 bits explicit
    function automatic logic [233:0] mk(input logic [31:0] lo, input logic [9:0] top);
        logic [233:0] f;
        f[31:0] = lo;
        for (int k = 1; k < 7; k++) f[32*k +: 32] = lo ^ (32'h1111_1111 * k);
        f[233:224] = top;
        return f;
    endfunction

    task automatic rd(input int frame, input int word);
        rd_en_i   = 1'b1;
        rd_addr_i = {frame[3:0], word[2:0]};
    endtask

    initial begin
        rst = 1'b1; uplinkrdy_i = 1'b0; uplinkUserData_i = '0; uplinkFEC_i = 1'b0;
        arm_i = 1'b0; abort_i = 1'b0; trig_mask_i = '0; trig_value_i = '0;
        capture_len_i = 5'd4; rd_en_i = 1'b0; rd_addr_i = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rdvalid", 32'(rd_valid_o), 32'd0);
        chk("rst_rddata", rd_data_o, 32'd0);
        chk("rst_fc", 32'(frames_captured_o), 32'd0);
        chk("rst_fec", 32'(fec_count_o), 32'd0);
        chk("rst_rl", 32'(rdy_loss_count_o), 32'd0);

        // basic capture, len 4, mask 0
        uplinkrdy_i = 1'b1; arm_i = 1'b1; uplinkUserData_i = mk(32'd100, 10'd100);
        tick();
        chk("t1_armed", 32'(state_o), 32'd1);
        arm_i = 1'b0;
        for (int n = 101; n <= 104; n++) begin
            uplinkUserData_i = mk(32'(n), n[0] ? 10'h3FF : n[9:0]);
            tick();
            if (n < 104) begin
                chk("t1_cap_state", 32'(state_o), 32'd2);
                chk("t1_cap_done", 32'(done_o), 32'd0);
                chk("t1_cap_fc", 32'(frames_captured_o), 32'(n - 100));
            end
        end
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_state", 32'(state_o), 32'd3);
        chk("t1_fc", 32'(frames_captured_o), 32'd4);
        uplinkUserData_i = mk(32'd999, 10'd0);
        tick();
        chk("t1_hold_fc", 32'(frames_captured_o), 32'd4);
        rd(0, 0); tick();
        chk("t1_rv0", 32'(rd_valid_o), 32'd1);
        chk("t1_f0w0", rd_data_o, 32'h0000_0065);
        rd(1, 2); tick();
        chk("t1_rv1", 32'(rd_valid_o), 32'd1);
        chk("t1_f1w2", rd_data_o, 32'h2222_2244);
        rd(0, 7); tick();
        chk("t1_f0w7", rd_data_o, 32'h0000_03FF);
        rd(3, 7); tick();
        chk("t1_f3w7", rd_data_o, 32'h0000_0068);
        rd(5, 0); tick();
        chk("t1_f5_oob", rd_data_o, 32'd0);
        chk("t1_rv5", 32'(rd_valid_o), 32'd1);
        rd_en_i = 1'b0; tick();
        chk("t1_rv_off", 32'(rd_valid_o), 32'd0);

        // full-mask trigger, len 2
        trig_mask_i = 32'hFFFF_FFFF; trig_value_i = 32'h1234_5678; capture_len_i = 5'd2;
        arm_i = 1'b1; uplinkUserData_i = mk(32'h1234_5678, 10'd0);
        tick();
        arm_i = 1'b0;
        chk("t2_arm_noeligible", 32'(state_o), 32'd1);
        uplinkUserData_i = mk(32'h0000_0001, 10'd0); tick();
        chk("t2_nohit1", 32'(state_o), 32'd1);
        uplinkUserData_i = mk(32'h0000_0002, 10'd0); tick();
        chk("t2_nohit2_fc", 32'(frames_captured_o), 32'd0);
        uplinkUserData_i = mk(32'h1234_5678, 10'd0); tick();
        chk("t2_hit_state", 32'(state_o), 32'd2);
        chk("t2_hit_fc", 32'(frames_captured_o), 32'd1);
        uplinkUserData_i = mk(32'h0000_AAAA, 10'd0); tick();
        chk("t2_done", 32'(state_o), 32'd3);
        rd(0, 0); tick();
        chk("t2_f0w0", rd_data_o, 32'h1234_5678);
        rd(1, 0); tick();
        chk("t2_f1w0", rd_data_o, 32'h0000_AAAA);
        rd(2, 0); tick();
        chk("t2_f2_oob", rd_data_o, 32'd0);
        rd_en_i = 1'b0;

        // rdy dropout mid-capture, len 3
        trig_mask_i = 32'd0; capture_len_i = 5'd3;
        arm_i = 1'b1; tick();
        arm_i = 1'b0;
        uplinkUserData_i = mk(32'h10, 10'd0); tick();
        chk("t3_fc1", 32'(frames_captured_o), 32'd1);
        uplinkrdy_i = 1'b0; uplinkFEC_i = 1'b1; uplinkUserData_i = mk(32'h11, 10'd0); tick();
        chk("t3_skip1_fc", 32'(frames_captured_o), 32'd1);
        chk("t3_rl", 32'(rdy_loss_count_o), 32'd1);
        chk("t3_fec_invalid", 32'(fec_count_o), 32'd0);
        uplinkFEC_i = 1'b0; uplinkUserData_i = mk(32'h12, 10'd0); tick();
        chk("t3_skip2_fc", 32'(frames_captured_o), 32'd1);
        chk("t3_skip2_state", 32'(state_o), 32'd2);
        uplinkrdy_i = 1'b1; uplinkFEC_i = 1'b1; uplinkUserData_i = mk(32'h13, 10'd0); tick();
        chk("t3_fc2", 32'(frames_captured_o), 32'd2);
        chk("t3_fec", 32'(fec_count_o), 32'd1);
        uplinkFEC_i = 1'b0; uplinkUserData_i = mk(32'h14, 10'd0); tick();
        chk("t3_fc3", 32'(frames_captured_o), 32'd3);
        chk("t3_done", 32'(done_o), 32'd1);
        chk("t3_rl_final", 32'(rdy_loss_count_o), 32'd1);
        rd(1, 0); tick();
        chk("t3_f1w0", rd_data_o, 32'h13);
        rd(2, 0); tick();
        chk("t3_f2w0", rd_data_o, 32'h14);
        rd_en_i = 1'b0;

        // read while ARMED returns zero with valid
        trig_mask_i = 32'hFFFF_FFFF; trig_value_i = 32'hDEAD_BEEF;
        uplinkUserData_i = mk(32'h0, 10'd0);
        arm_i = 1'b1; tick();
        arm_i = 1'b0;
        rd(0, 0); tick();
        chk("t4_armed_state", 32'(state_o), 32'd1);
        chk("t4_armed_rv", 32'(rd_valid_o), 32'd1);
        chk("t4_armed_rd", rd_data_o, 32'd0);
        rd_en_i = 1'b0;

        // arm/abort priority and re-arm during CAPTURE
        trig_mask_i = 32'd0; capture_len_i = 5'd4;
        arm_i = 1'b1; tick();
        arm_i = 1'b0; uplinkFEC_i = 1'b1; uplinkUserData_i = mk(32'h50, 10'd0); tick();
        chk("t5_cap", 32'(state_o), 32'd2);
        chk("t5_fec1", 32'(fec_count_o), 32'd1);
        uplinkFEC_i = 1'b0; arm_i = 1'b1; abort_i = 1'b1; tick();
        chk("t5_abort_state", 32'(state_o), 32'd0);
        chk("t5_abort_fc", 32'(frames_captured_o), 32'd1);
        chk("t5_abort_fec", 32'(fec_count_o), 32'd1);
        abort_i = 1'b0; tick();
        chk("t5_rearm_fec", 32'(fec_count_o), 32'd0);
        arm_i = 1'b0; tick();
        chk("t5_cap2", 32'(state_o), 32'd2);
        arm_i = 1'b1; tick();
        arm_i = 1'b0;
        chk("t5_arm_in_cap", 32'(state_o), 32'd1);
        chk("t5_arm_in_cap_fc", 32'(frames_captured_o), 32'd0);

        // synchronous reset mid-capture
        uplinkFEC_i = 1'b1; tick();
        chk("t6_cap", 32'(state_o), 32'd2);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("t6_rst_state", 32'(state_o), 32'd0);
        chk("t6_rst_fc", 32'(frames_captured_o), 32'd0);
        chk("t6_rst_fec", 32'(fec_count_o), 32'd0);

        // FEC count saturation and clear on arm
        repeat (65540) @(posedge clk40);
        #1;
        chk("t7_fec_sat", 32'(fec_count_o), 32'h0000_FFFF);
        chk("t7_idle", 32'(state_o), 32'd0);
        arm_i = 1'b1; tick();
        arm_i = 1'b0;
        chk("t7_fec_clr", 32'(fec_count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
